// File: rtl/av_arbiter_2to1_pkg.sv
// Shared state encodings and response codes for the 2:1 Avalon-MM arbiter.
package av_arbiter_2to1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] AV_RESP_OKAY = 2'b00;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/av_arb_rr.sv
// Two-input request picker: reqs + last owner -> one-hot winner.
// AV_ARB_FIXED_PRIO_EN makes master 0 win ties; default is round-robin.
import av_arbiter_2to1_pkg::*;

module av_arb_rr (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] win
);

`ifdef AV_ARB_FIXED_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        win = 2'b00;
        if (req[0])      win = 2'b01;
        else if (req[1]) win = 2'b10;
    end
`else
    always_comb begin
        win = 2'b00;
        if (req == 2'b11) win = onehot2(~last_owner);
        else              win = req;
    end
`endif

endmodule

// File: rtl/av_arbiter_2to1.sv
// Two-master to one-slave Avalon-MM arbiter holding the grant for a whole burst.
// Tie-break policy selected by AV_ARB_FIXED_PRIO_EN (see av_arb_rr).
import av_arbiter_2to1_pkg::*;

module av_arbiter_2to1 #(
    parameter int aw = 32,
    parameter int dw = 32,
    parameter int bw = 3
) (
    input  logic            av_clk_i,
    input  logic            av_rst_i,
    input  logic [aw-1:0]   m0_av_address_i,
    input  logic [dw-1:0]   m0_av_writedata_i,
    input  logic [dw/8-1:0] m0_av_byteenable_i,
    input  logic [bw-1:0]   m0_av_burstcount_i,
    input  logic            m0_av_write_i,
    input  logic            m0_av_read_i,
    output logic            m0_av_waitrequest_o,
    output logic [1:0]      m0_av_response_o,
    output logic [dw-1:0]   m0_av_readdata_o,
    input  logic [aw-1:0]   m1_av_address_i,
    input  logic [dw-1:0]   m1_av_writedata_i,
    input  logic [dw/8-1:0] m1_av_byteenable_i,
    input  logic [bw-1:0]   m1_av_burstcount_i,
    input  logic            m1_av_write_i,
    input  logic            m1_av_read_i,
    output logic            m1_av_waitrequest_o,
    output logic [1:0]      m1_av_response_o,
    output logic [dw-1:0]   m1_av_readdata_o,
    output logic [aw-1:0]   s_av_address_o,
    output logic [dw-1:0]   s_av_writedata_o,
    output logic [dw/8-1:0] s_av_byteenable_o,
    output logic [bw-1:0]   s_av_burstcount_o,
    output logic            s_av_write_o,
    output logic            s_av_read_o,
    input  logic            s_av_waitrequest_i,
    input  logic [1:0]      s_av_response_i,
    input  logic [dw-1:0]   s_av_readdata_i,
    output logic [1:0]      grant_o
);

    localparam int bew = dw / 8;

    logic [1:0][aw-1:0]  m_addr;
    logic [1:0][dw-1:0]  m_wdata;
    logic [1:0][bew-1:0] m_be;
    logic [1:0][bw-1:0]  m_bc;
    logic [1:0]          m_wr, m_rd, m_req;
    logic [1:0]          m_wait;
    logic [1:0][1:0]     m_resp;
    logic [1:0][dw-1:0]  m_rdata;

    assign m_addr  = {m1_av_address_i,    m0_av_address_i};
    assign m_wdata = {m1_av_writedata_i,  m0_av_writedata_i};
    assign m_be    = {m1_av_byteenable_i, m0_av_byteenable_i};
    assign m_bc    = {m1_av_burstcount_i, m0_av_burstcount_i};
    assign m_wr    = {m1_av_write_i,      m0_av_write_i};
    assign m_rd    = {m1_av_read_i,       m0_av_read_i};
    assign m_req   = m_wr | m_rd;

    assign m0_av_waitrequest_o = m_wait[0];
    assign m1_av_waitrequest_o = m_wait[1];
    assign m0_av_response_o    = m_resp[0];
    assign m1_av_response_o    = m_resp[1];
    assign m0_av_readdata_o    = m_rdata[0];
    assign m1_av_readdata_o    = m_rdata[1];

    arb_state_e  state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic [bw:0] beat_cnt_q, beat_cnt_d;
    logic [bw:0] burst_len_q, burst_len_d;

    logic [1:0]  win;
    logic        owner, active, cmd, accept, done;
    logic [bw:0] first_len, len_eff, beat_nxt;

    av_arb_rr u_rr (
        .req        (m_req),
        .last_owner (last_owner_q),
        .win        (win)
    );

    // Reset gates the outputs combinationally so the slave sees no strobe
    // in the very cycle reset is asserted, even mid-burst.
    always_comb begin
        active    = !av_rst_i && (state_q != ST_IDLE);
        owner     = (state_q == ST_GNT1);
        cmd       = m_req[owner];
        accept    = active && cmd && !s_av_waitrequest_i;
        first_len = (m_bc[owner] == '0) ? (bw+1)'(1) : {1'b0, m_bc[owner]};
        len_eff   = (beat_cnt_q == '0) ? first_len : burst_len_q;
        beat_nxt  = beat_cnt_q + (bw+1)'(1);
        done      = accept && (beat_nxt == len_eff);
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        burst_len_d  = burst_len_q;
        case (state_q)
            ST_IDLE: begin
                if (win[0])      state_d = ST_GNT0;
                else if (win[1]) state_d = ST_GNT1;
            end
            ST_GNT0, ST_GNT1: begin
                if (accept) begin
                    beat_cnt_d = beat_nxt;
                    if (beat_cnt_q == '0) burst_len_d = first_len;
                end
                if (done) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner;
                    beat_cnt_d   = '0;
                end else if (!cmd && beat_cnt_q == '0) begin
                    // Owner withdrew before any beat: release without
                    // counting it as a turn.
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge av_clk_i) begin
        if (av_rst_i) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            beat_cnt_q   <= '0;
            burst_len_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            burst_len_q  <= burst_len_d;
        end
    end

    always_comb begin
        s_av_address_o    = '0;
        s_av_writedata_o  = '0;
        s_av_byteenable_o = '0;
        s_av_burstcount_o = '0;
        s_av_write_o      = 1'b0;
        s_av_read_o       = 1'b0;
        m_wait            = 2'b11;
        m_resp            = {AV_RESP_OKAY, AV_RESP_OKAY};
        m_rdata           = '0;
        grant_o           = 2'b00;
        if (active) begin
            s_av_address_o    = m_addr[owner];
            s_av_writedata_o  = m_wdata[owner];
            s_av_byteenable_o = m_be[owner];
            s_av_burstcount_o = m_bc[owner];
            s_av_write_o      = m_wr[owner];
            s_av_read_o       = m_rd[owner];
            m_wait[owner]     = s_av_waitrequest_i;
            m_resp[owner]     = s_av_response_i;
            m_rdata[owner]    = s_av_readdata_i;
            grant_o           = onehot2(owner);
        end
    end

endmodule

// File: tb/tb_av_arbiter_2to1.sv
// Directed bench for av_arbiter_2to1 with a cycle-level ownership model and a
// small memory slave; honours AV_ARB_FIXED_PRIO_EN.
module tb_av_arbiter_2to1;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [3:0]    m_be    [2];
    logic [BW-1:0] m_bc    [2];
    logic          m_wr    [2];
    logic          m_rd    [2];
    logic          m_wait  [2];
    logic [1:0]    m_resp  [2];
    logic [DW-1:0] m_rdata [2];

    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [3:0]    s_be;
    logic [BW-1:0] s_bc;
    logic          s_write, s_read, s_wait;
    logic [1:0]    s_resp;
    logic [DW-1:0] s_rdata;
    logic [1:0]    grant;

    int cyc = 0;
    int n_pass = 0;
    int n_chk = 0;
    logic stall_en = 1'b0;
    logic [31:0] mem [0:63];

    av_arbiter_2to1 #(.aw(AW), .dw(DW), .bw(BW)) dut (
        .av_clk_i(clk), .av_rst_i(rst),
        .m0_av_address_i(m_addr[0]), .m0_av_writedata_i(m_wdata[0]),
        .m0_av_byteenable_i(m_be[0]), .m0_av_burstcount_i(m_bc[0]),
        .m0_av_write_i(m_wr[0]), .m0_av_read_i(m_rd[0]),
        .m0_av_waitrequest_o(m_wait[0]), .m0_av_response_o(m_resp[0]),
        .m0_av_readdata_o(m_rdata[0]),
        .m1_av_address_i(m_addr[1]), .m1_av_writedata_i(m_wdata[1]),
        .m1_av_byteenable_i(m_be[1]), .m1_av_burstcount_i(m_bc[1]),
        .m1_av_write_i(m_wr[1]), .m1_av_read_i(m_rd[1]),
        .m1_av_waitrequest_o(m_wait[1]), .m1_av_response_o(m_resp[1]),
        .m1_av_readdata_o(m_rdata[1]),
        .s_av_address_o(s_addr), .s_av_writedata_o(s_wdata),
        .s_av_byteenable_o(s_be), .s_av_burstcount_o(s_bc),
        .s_av_write_o(s_write), .s_av_read_o(s_read),
        .s_av_waitrequest_i(s_wait), .s_av_response_i(s_resp),
        .s_av_readdata_i(s_rdata), .grant_o(grant)
    );

    // Memory slave: zero-latency reads, SLVERR for addresses with bit 8 set.
    assign s_wait  = stall_en && (cyc % 3 == 1);
    assign s_rdata = s_read ? mem[s_addr[7:2]] : 32'h0;
    assign s_resp  = s_addr[8] ? 2'b10 : 2'b00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_write && !s_wait)
            for (int b = 0; b < 4; b++)
                if (s_be[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Ownership model: who holds the bus, whose turn is next, beats left.
    int mo_owner = -1;
    int mo_last  = 1;
    int mo_beats = 0;
    int mo_len   = 0;

    always @(posedge clk) begin : model
        int o, l, b, n;
        bit r0, r1, c;
        o = mo_owner; l = mo_last; b = mo_beats; n = mo_len;
        if (rst) begin
            o = -1; l = 1; b = 0; n = 0;
        end else if (o < 0) begin
            r0 = m_rd[0] | m_wr[0];
            r1 = m_rd[1] | m_wr[1];
`ifdef AV_ARB_FIXED_PRIO_EN
            if (r0)      o = 0;
            else if (r1) o = 1;
`else
            if (r0 && r1) o = 1 - l;
            else if (r0)  o = 0;
            else if (r1)  o = 1;
`endif
        end else begin
            c = m_rd[o] | m_wr[o];
            if (c && !s_wait) begin
                if (b == 0) n = (m_bc[o] == 0) ? 1 : int'(m_bc[o]);
                b = b + 1;
                if (b == n) begin l = o; o = -1; b = 0; end
            end else if (!c && b == 0) begin
                o = -1;
            end
        end
        mo_owner <= o; mo_last <= l; mo_beats <= b; mo_len <= n;
    end

    always @(negedge clk) begin : compare
        int o;
        o = rst ? -1 : mo_owner;
        check("grant", grant, (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10));
        for (int m = 0; m < 2; m++) begin
            check("waitreq", m_wait[m], (o == m) ? s_wait : 1'b1);
            check("readdata", m_rdata[m],
                  (o == m && m_rd[m]) ? mem[m_addr[m][7:2]] : 32'h0);
            check("response", m_resp[m],
                  (o == m && m_addr[m][8]) ? 2'b10 : 2'b00);
        end
        if (o >= 0) begin
            check("s_addr",  s_addr,  m_addr[o]);
            check("s_wdata", s_wdata, m_wdata[o]);
            check("s_be",    s_be,    m_be[o]);
            check("s_bc",    s_bc,    m_bc[o]);
            check("s_write", s_write, m_wr[o]);
            check("s_read",  s_read,  m_rd[o]);
        end else begin
            check("s_write_idle", s_write, 1'b0);
            check("s_read_idle",  s_read,  1'b0);
        end
    end

    // One transfer of bc beats from master m; called at posedge+1.
    task automatic xfer(input int m, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int bc,
                        output logic [31:0] rd, output int first_cyc,
                        output int last_cyc, output logic [1:0] gnt_seen);
        int beats = 0;
        int guard = 0;
        int need  = (bc == 0) ? 1 : bc;
        rd = 0; first_cyc = -1; last_cyc = -1; gnt_seen = 2'b00;
        m_addr[m] = addr; m_be[m] = 4'hF; m_bc[m] = BW'(bc);
        m_wdata[m] = data; m_wr[m] = wr; m_rd[m] = !wr;
        while (beats < need && guard < 200) begin
            @(negedge clk);
            guard++;
            if (!m_wait[m]) begin
                if (beats == 0) first_cyc = cyc;
                last_cyc = cyc; rd = m_rdata[m]; gnt_seen = grant;
                beats++;
            end
            @(posedge clk); #1;
            m_wdata[m] = data + beats;
        end
        if (beats < need) check("xfer_timeout", beats, need);
        m_wr[m] = 1'b0; m_rd[m] = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, rd1;
        logic [1:0]  g, g1;
        int f0, l0, f1, l1, start, beats, guard, m0_end;
        int order[$];

        for (int m = 0; m < 2; m++) begin
            m_addr[m] = 0; m_wdata[m] = 0; m_be[m] = 0; m_bc[m] = 0;
            m_wr[m] = 1'b0; m_rd[m] = 1'b0;
        end

        // 1: reset held 10 cycles with both masters requesting
        m_rd[0] = 1'b1; m_rd[1] = 1'b1; m_addr[1] = 32'h4;
        repeat (10) begin
            @(negedge clk);
            check("rst_grant", grant, 2'b00);
            check("rst_wait0", m_wait[0], 1'b1);
            check("rst_wait1", m_wait[1], 1'b1);
            check("rst_sread", s_read, 1'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0; m_rd[0] = 1'b0; m_rd[1] = 1'b0;

        // 2: m0 single write then read back, one cycle of arbitration latency
        start = cyc;
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 1, rd, f0, l0, g);
        check("t2_latency", f0 - start, 1);
        check("t2_wr_grant", g, 2'b01);
        xfer(0, 1'b0, 32'h10, 32'h0, 1, rd, f0, l0, g);
        check("t2_rdata", rd, 32'hDEADBEEF);
        check("t2_rd_grant", g, 2'b01);

`ifndef AV_ARB_FIXED_PRIO_EN
        // 3: simultaneous requests alternate, m0 first after reset, with stalls
        pulse_reset();
        stall_en = 1'b1;
        fork
            for (int i = 0; i < 10; i++) begin
                logic [31:0] r; int a, b; logic [1:0] gg;
                xfer(0, 1'b1, 32'h40 + 4*i, 32'hA000 + i, 1, r, a, b, gg);
                order.push_back(0);
            end
            for (int i = 0; i < 10; i++) begin
                logic [31:0] r; int a, b; logic [1:0] gg;
                xfer(1, 1'b1, 32'h1C0 + 4*i, 32'hB000 + i, 1, r, a, b, gg);
                order.push_back(1);
            end
        join
        stall_en = 1'b0;
        check("t3_count", order.size(), 20);
        foreach (order[i]) check("t3_order", order[i], i % 2);
        check("t3_mem_m1", mem[6'd50], 32'hB002);
`endif

        // 4: m0 burst of 4; m1 requests mid-burst and waits for IDLE + grant
        fork
            xfer(0, 1'b1, 32'h20, 32'h100, 4, rd, f0, l0, g);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                xfer(1, 1'b0, 32'h24, 32'h0, 1, rd1, f1, l1, g1);
            end
        join
        check("t4_burst_len", l0 - f0, 3);
        check("t4_m1_after", f1 - l0, 2);
        check("t4_m1_grant", g1, 2'b10);
        check("t4_mem_last", mem[6'd8], 32'h103);

        // 5: reset after beat 2 of a 4-beat m1 burst
        m_addr[1] = 32'h30; m_bc[1] = 3'd4; m_be[1] = 4'hF;
        m_wdata[1] = 32'h55; m_wr[1] = 1'b1;
        beats = 0; guard = 0;
        while (beats < 2 && guard < 50) begin
            @(negedge clk);
            guard++;
            if (!m_wait[1]) beats++;
            @(posedge clk); #1;
        end
        check("t5_two_beats", beats, 2);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_swrite", s_write, 1'b0);
        check("t5_rst_grant", grant, 2'b00);
        check("t5_rst_wait1", m_wait[1], 1'b1);
        @(posedge clk); #1;
        rst = 1'b0; m_wr[1] = 1'b0;
        @(negedge clk);
        check("t5_idle_grant", grant, 2'b00);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h10, 32'h0, 1, rd, f0, l0, g);
        check("t5_m0_grant", g, 2'b01);
        check("t5_m0_rdata", rd, 32'hDEADBEEF);

`ifdef AV_ARB_FIXED_PRIO_EN
        // 6: m0 requests continuously; m1 only gets in once m0 stops
        m0_end = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    logic [31:0] r; int a; logic [1:0] gg;
                    xfer(0, 1'b1, 32'h40 + 4*i, 32'hC000 + i, 1, r, a, m0_end, gg);
                end
            end
            xfer(1, 1'b1, 32'h1C0, 32'hD000, 1, rd1, f1, l1, g1);
        join
        check("t6_m1_after_m0", f1 - m0_end, 2);
        check("t6_m1_grant", g1, 2'b10);
`else
        m0_end = 0;
        check("t6_unused", m0_end, 0);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
